exp_adder_pipe: RTL and testbench
=================================

EXP_ADDER_PIPE -- requirements
Module: exp_adder_pipe

Interface
REQ-001 Parameter EW, default 8, exponent field width in bits (EW >= 2).
REQ-002 Parameter BIAS, default 127, exponent bias, 0 <= BIAS <= 2^EW-1.
REQ-003 Parameter CW, default 8, width of the saturation-event counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  operand pair valid.
REQ-007 in_ready  out  1  block can accept an operand pair this cycle.
REQ-008 op  in  1  0 = add (exponent multiply), 1 = subtract (exponent divide).
REQ-009 bias_en  in  1  1 = apply bias correction; 0 = plain add/subtract.
REQ-010 a  in  EW  unsigned biased exponent A.
REQ-011 b  in  EW  unsigned biased exponent B.
REQ-012 out_valid  out  1  result valid.
REQ-013 out_ready  in  1  consumer accepts the result this cycle.
REQ-014 y  out  EW  saturated result exponent.
REQ-015 ovf  out  1  result clamped high; qualified by out_valid.
REQ-016 unf  out  1  result clamped low; qualified by out_valid.
REQ-017 sat_cnt  out  CW  count of results delivered with ovf or unf.
REQ-018 cnt_clr  in  1  synchronous clear of sat_cnt.

Function
REQ-019 Transfer in: in_valid & in_ready; transfer out: out_valid & out_ready.
REQ-020 Two-stage pipeline: S1 registers raw result, S2 registers saturated result and flags; fixed latency 2 cycles from input transfer to out_valid when not stalled.
REQ-021 S1 raw result, signed EW+2 bits: op=0 -> a+b-(bias_en?BIAS:0); op=1 -> a-b+(bias_en?BIAS:0).
REQ-022 S2: raw > 2^EW-1 -> y = all ones, ovf=1; raw < 0 -> y = 0, unf=1; otherwise y = raw[EW-1:0], ovf=unf=0.
REQ-023 Exactly 0 and exactly 2^EW-1 are in range; no flag.
REQ-024 S2 loads when S2 empty or out_ready=1; S1 advances under the same condition; in_ready = !S1_valid | S2 loads.
REQ-025 Full throughput: one transfer per cycle with out_ready held high.
REQ-026 Stall: out_ready=0 with S2 full holds y, ovf, unf, out_valid stable; at most 2 pairs buffered; in_ready drops once both stages are full.
REQ-027 Simultaneous output transfer and input transfer in the same cycle is legal; no bubble, no loss, order preserved.
REQ-028 sat_cnt increments on each output transfer with ovf|unf; saturates at 2^CW-1, no wrap.
REQ-029 cnt_clr has priority over increment in the same cycle; sat_cnt = 0 next cycle.
REQ-030 in_ready shall not depend combinationally on in_valid.

Reset
REQ-031 rst_n low: S1/S2 valid = 0, out_valid = 0, y = 0, ovf = 0, unf = 0, sat_cnt = 0, immediately and asynchronously.
REQ-032 in_ready = 1 during and after reset.
REQ-033 Reset mid-operation discards all in-flight pairs; no output transfer of pre-reset data after rst_n deasserts.

Structure
REQ-034 Shared package holds: default EW/BIAS/CW constants, op encoding constants (OP_ADD=0, OP_SUB=1).
REQ-035 One sub-module, exp_sat, combinational clamp of EW+2-bit signed value to EW bits with ovf/unf outputs; instantiated in S2.
REQ-036 Target 120-400 lines RTL; no other sub-modules.

Verification (EW=8, BIAS=127, CW=8)
REQ-037 op=0, bias_en=1, a=130, b=127, out_ready=1 -> 2 cycles later y=130, ovf=0, unf=0.
REQ-038 op=0, bias_en=1, a=200, b=200 -> y=255, ovf=1; op=1, bias_en=1, a=10, b=200 -> y=0, unf=1; sat_cnt=2.
REQ-039 op=0, bias_en=0, a=255, b=0 -> y=255, no flag; a=128, b=128 -> y=255, ovf=1.
REQ-040 3 back-to-back pairs with out_ready=0 -> 2 accepted, in_ready=0 on third; out_ready=1 -> results delivered in order, third accepted, no loss.
REQ-041 rst_n low for 1 cycle with 2 pairs in flight -> out_valid=0, sat_cnt=0, in_ready=1; no stale result after release.
REQ-042 256 consecutive ovf results -> sat_cnt holds at 255; cnt_clr coincident with an ovf result -> sat_cnt=0.

Source files
------------

// File: rtl/exp_adder_pipe_pkg.sv
// Shared constants for the biased-exponent add/subtract pipeline.
package exp_adder_pipe_pkg;

    localparam int DEF_EW   = 8;
    localparam int DEF_BIAS = 127;
    localparam int DEF_CW   = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/exp_sat.sv
// Clamp a signed EW+2-bit exponent to the unsigned EW-bit range, flagging
// which side was clamped.
module exp_sat
    import exp_adder_pipe_pkg::*;
#(
    parameter int EW = DEF_EW
) (
    input  logic signed [EW+1:0] raw_i,
    output logic        [EW-1:0] y_o,
    output logic                 ovf_o,
    output logic                 unf_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        y_o   = raw_i[EW-1:0];
        ovf_o = 1'b0;
        unf_o = 1'b0;
        if (raw_i[EW+1]) begin
            y_o   = '0;
            unf_o = 1'b1;
        end else if (raw_i[EW]) begin
            // Non-negative with bit EW set means the value is at least 2^EW.
            y_o   = '1;
            ovf_o = 1'b1;
        end
    end

endmodule

// File: rtl/exp_adder_pipe.sv
// Two-stage exponent add/subtract with optional bias correction, saturation,
// valid/ready flow control and a saturating count of clamped results.
module exp_adder_pipe
    import exp_adder_pipe_pkg::*;
#(
    parameter int EW   = DEF_EW,
    parameter int BIAS = DEF_BIAS,
    parameter int CW   = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          op,
    input  logic          bias_en,
    input  logic [EW-1:0] a,
    input  logic [EW-1:0] b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [EW-1:0] y,
    output logic          ovf,
    output logic          unf,
    output logic [CW-1:0] sat_cnt,
    input  logic          cnt_clr
);

    localparam logic signed [EW+1:0] BIAS_X  = (EW+2)'(BIAS);
    localparam logic        [CW-1:0] CNT_MAX = '1;

    logic                 s1_valid_q;
    logic signed [EW+1:0] s1_raw_q, s1_raw_d;
    logic                 s2_valid_q;
    logic        [EW-1:0] y_q, y_d;
    logic                 ovf_q, ovf_d, unf_q, unf_d;
    logic        [CW-1:0] cnt_q;
    logic                 s2_load;
    logic                 out_xfer;

    // S2 frees up when empty or draining; S1 may then refill in the same cycle.
    assign s2_load  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;
    assign out_xfer = s2_valid_q && out_ready;

    always_comb begin
        logic signed [EW+1:0] a_ext, b_ext, bias_ext;
        a_ext    = signed'({2'b00, a});
        b_ext    = signed'({2'b00, b});
        bias_ext = bias_en ? BIAS_X : '0;
        s1_raw_d = a_ext + b_ext - bias_ext;
        case (op)
            OP_ADD:  s1_raw_d = a_ext + b_ext - bias_ext;
            OP_SUB:  s1_raw_d = a_ext - b_ext + bias_ext;
            default: s1_raw_d = a_ext + b_ext - bias_ext;
        endcase
    end

    exp_sat #(.EW(EW)) u_sat (
        .raw_i (s1_raw_q),
        .y_o   (y_d),
        .ovf_o (ovf_d),
        .unf_o (unf_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_raw_q   <= '0;
        end else if (in_ready) begin
            // NOTE: state registers use non-blocking assignment so all flops sample together.
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_raw_q <= s1_raw_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                y_q   <= y_d;
                ovf_q <= ovf_d;
                unf_q <= unf_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (out_xfer && (ovf_q || unf_q) && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign out_valid = s2_valid_q;
    assign y         = y_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign sat_cnt   = cnt_q;

endmodule

// File: tb/tb_exp_adder_pipe.sv
// Directed bench for exp_adder_pipe at EW=8, BIAS=127, CW=8.
module tb_exp_adder_pipe;

    localparam int EW   = 8;
    localparam int BIAS = 127;
    localparam int CW   = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          op = 1'b0;
    logic          bias_en = 1'b0;
    logic [EW-1:0] a = '0;
    logic [EW-1:0] b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [EW-1:0] y;
    logic          ovf;
    logic          unf;
    logic [CW-1:0] sat_cnt;
    logic          cnt_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    exp_adder_pipe #(.EW(EW), .BIAS(BIAS), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .bias_en   (bias_en),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf),
        .unf       (unf),
        .sat_cnt   (sat_cnt),
        .cnt_clr   (cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic o, input logic be, input logic [EW-1:0] av, input logic [EW-1:0] bv);
        in_valid = 1'b1;
        op       = o;
        bias_en  = be;
        a        = av;
        b        = bv;
    endtask

    // One pair with out_ready high; returns with its result on the outputs.
    task automatic send_one(input logic o, input logic be, input logic [EW-1:0] av, input logic [EW-1:0] bv);
        out_ready = 1'b1;
        drive(o, be, av, bv);
        cyc();
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic expect_result(input string name, input logic [EW-1:0] ey, input logic eo, input logic eu);
        checks++;
        if (out_valid !== 1'b1 || y !== ey || ovf !== eo || unf !== eu) begin
            errors++;
            $display("FAIL %s: got valid=%b y=%0d ovf=%b unf=%b, want valid=1 y=%0d ovf=%b unf=%b",
                     name, out_valid, y, ovf, unf, ey, eo, eu);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (out_valid !== 1'b0 || y !== '0 || ovf !== 1'b0 || unf !== 1'b0 || sat_cnt !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got valid=%b y=%0d ovf=%b unf=%b cnt=%0d rdy=%b, want 0 0 0 0 0 1",
                     out_valid, y, ovf, unf, sat_cnt, in_ready);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got rdy=%b valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        drive(1'b0, 1'b1, 8'd130, 8'd127);
        cyc();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency1: got valid=%b, want 0", out_valid);
        end
        cyc();
        expect_result("basic_130", 8'd130, 1'b0, 1'b0);
        cyc();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain: got valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_saturate();
        send_one(1'b0, 1'b1, 8'd200, 8'd200);
        expect_result("sat_ovf_273", 8'd255, 1'b1, 1'b0);
        cyc();
        send_one(1'b1, 1'b1, 8'd10, 8'd200);
        expect_result("sat_unf_m63", 8'd0, 1'b0, 1'b1);
        cyc();
        checks++;
        if (sat_cnt !== 8'd2) begin
            errors++;
            $display("FAIL sat_cnt_2: got %0d, want 2", sat_cnt);
        end
    endtask

    task automatic test_bounds();
        send_one(1'b0, 1'b0, 8'd255, 8'd0);
        expect_result("bound_255", 8'd255, 1'b0, 1'b0);
        cyc();
        send_one(1'b0, 1'b0, 8'd128, 8'd128);
        expect_result("bound_256", 8'd255, 1'b1, 1'b0);
        cyc();
        send_one(1'b1, 1'b0, 8'd5, 8'd5);
        expect_result("bound_zero", 8'd0, 1'b0, 1'b0);
        cyc();
        checks++;
        if (sat_cnt !== 8'd3) begin
            errors++;
            $display("FAIL bound_cnt: got %0d, want 3", sat_cnt);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(1'b0, 1'b0, 8'd1, 8'd2);
        cyc();
        drive(1'b0, 1'b0, 8'd10, 8'd20);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_ready: got %b, want 1", in_ready);
        end
        cyc();
        drive(1'b0, 1'b0, 8'd100, 8'd1);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full_ready: got %b, want 0", in_ready);
        end
        expect_result("b2b_head", 8'd3, 1'b0, 1'b0);
        cyc();
        expect_result("b2b_stall_hold", 8'd3, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall_ready: got %b, want 0", in_ready);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_release_ready: got %b, want 1", in_ready);
        end
        cyc();
        in_valid = 1'b0;
        expect_result("b2b_second", 8'd30, 1'b0, 1'b0);
        cyc();
        expect_result("b2b_third", 8'd101, 1'b0, 1'b0);
        cyc();
        checks++;
        if (out_valid !== 1'b0 || sat_cnt !== 8'd3) begin
            errors++;
            $display("FAIL b2b_end: got valid=%b cnt=%0d, want 0 3", out_valid, sat_cnt);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b0, 1'b0, 8'd200, 8'd200);
        cyc();
        drive(1'b0, 1'b0, 8'd255, 8'd255);
        cyc();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmid_full: got valid=%b rdy=%b, want 1 0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sat_cnt !== '0 || in_ready !== 1'b1 || y !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async: got valid=%b cnt=%0d rdy=%b y=%0d ovf=%b, want 0 0 1 0 0",
                     out_valid, sat_cnt, in_ready, y, ovf);
        end
        cyc();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rmid_stale cycle %0d: got valid=%b y=%0d, want valid 0", i, out_valid, y);
            end
        end
        checks++;
        if (sat_cnt !== '0) begin
            errors++;
            $display("FAIL rmid_cnt: got %0d, want 0", sat_cnt);
        end
    endtask

    task automatic test_sat_cnt();
        int n_out;
        n_out = 0;
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 8'd255, 8'd255);
        for (int i = 0; i < 260; i++) begin
            cyc();
            if (out_valid === 1'b1) n_out++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (out_valid === 1'b1) n_out++;
        end
        checks++;
        if (n_out != 260) begin
            errors++;
            $display("FAIL stream_count: got %0d results, want 260", n_out);
        end
        checks++;
        if (sat_cnt !== 8'd255) begin
            errors++;
            $display("FAIL cnt_saturate: got %0d, want 255", sat_cnt);
        end
        drive(1'b0, 1'b0, 8'd255, 8'd255);
        cyc();
        in_valid = 1'b0;
        cyc();
        expect_result("clr_pending_ovf", 8'd255, 1'b1, 1'b0);
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        checks++;
        if (sat_cnt !== 8'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_priority: got cnt=%0d valid=%b, want 0 0", sat_cnt, out_valid);
        end
        cyc();
        checks++;
        if (sat_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clr_hold: got %0d, want 0", sat_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_bounds();
        test_back_to_back();
        test_reset_mid();
        test_sat_cnt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
